// File: rtl/bsg_lfu_ctrl.sv
// LFU replacement controller: per-set/per-way access-frequency counters,
// serial one-way-per-cycle victim scan, and whole-set halving on saturation.
module bsg_lfu_ctrl #(
    parameter int ways_p       = 8,
    parameter int sets_p       = 64,
    parameter int freq_width_p = 16,
    parameter int lg_ways_lp   = (ways_p == 1) ? 1 : $clog2(ways_p),
    parameter int lg_sets_lp   = (sets_p == 1) ? 1 : $clog2(sets_p)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  hit_v_i,
    input  logic [lg_sets_lp-1:0] hit_set_i,
    input  logic [lg_ways_lp-1:0] hit_way_i,
    output logic                  hit_ready_o,
    input  logic                  victim_v_i,
    input  logic [lg_sets_lp-1:0] victim_set_i,
    output logic                  victim_ready_o,
    output logic                  victim_v_o,
    output logic [lg_ways_lp-1:0] victim_way_o,
    input  logic                  victim_yumi_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2,
        S_AGE  = 2'd3
    } state_e;

    localparam logic [freq_width_p-1:0] cnt_max_lp  = {freq_width_p{1'b1}};
    localparam logic [freq_width_p-1:0] cnt_one_lp  = freq_width_p'(32'd1);
    localparam logic [lg_ways_lp-1:0]   way_one_lp  = lg_ways_lp'(32'd1);
    localparam logic [lg_ways_lp-1:0]   way_last_lp = lg_ways_lp'(ways_p - 1);

    state_e                  state_q, state_d;
    logic [lg_ways_lp-1:0]   idx_q, idx_d;
    logic [lg_sets_lp-1:0]   set_q, set_d;
    logic [lg_ways_lp-1:0]   age_way_q, age_way_d;
    logic [freq_width_p-1:0] min_q, min_d;
    logic [lg_ways_lp-1:0]   min_way_q, min_way_d;
    logic                    victim_v_q, victim_v_d;

    logic [freq_width_p-1:0] cnt_q [sets_p][ways_p];

    logic [lg_sets_lp-1:0]   rd_set_s;
    logic [lg_ways_lp-1:0]   rd_way_s;
    logic [freq_width_p-1:0] rd_cnt_s;
    logic                    wr_en_s;
    logic [lg_sets_lp-1:0]   wr_set_s;
    logic [lg_ways_lp-1:0]   wr_way_s;
    logic [freq_width_p-1:0] wr_cnt_s;

    // Held low during reset so nothing is accepted while state is being cleared.
    assign hit_ready_o    = (state_q == S_IDLE) & ~reset_i;
    assign victim_ready_o = hit_ready_o & ~hit_v_i;
    assign victim_v_o     = victim_v_q;
    assign victim_way_o   = min_way_q;

    // Counter read port: hit lookup in IDLE, walking index otherwise.
    always_comb begin
        if (state_q == S_IDLE) begin
            rd_set_s = hit_set_i;
            rd_way_s = hit_way_i;
        end else begin
            rd_set_s = set_q;
            rd_way_s = idx_q;
        end
        rd_cnt_s = cnt_q[rd_set_s][rd_way_s];
    end

    // Next-state, datapath updates and the single counter write port.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        set_d      = set_q;
        age_way_d  = age_way_q;
        min_d      = min_q;
        min_way_d  = min_way_q;
        victim_v_d = victim_v_q;
        wr_en_s    = 1'b0;
        wr_set_s   = set_q;
        wr_way_s   = idx_q;
        wr_cnt_s   = rd_cnt_s;

        case (state_q)
            S_IDLE: begin
                if (hit_v_i) begin
                    if (rd_cnt_s != cnt_max_lp) begin
                        wr_en_s  = 1'b1;
                        wr_set_s = hit_set_i;
                        wr_way_s = hit_way_i;
                        wr_cnt_s = rd_cnt_s + cnt_one_lp;
                    end else begin
                        set_d     = hit_set_i;
                        age_way_d = hit_way_i;
                        idx_d     = {lg_ways_lp{1'b0}};
                        state_d   = S_AGE;
                    end
                end else if (victim_v_i) begin
                    set_d   = victim_set_i;
                    idx_d   = {lg_ways_lp{1'b0}};
                    state_d = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                // Strict less-than keeps the lowest way on ties.
                if ((idx_q == {lg_ways_lp{1'b0}}) || (rd_cnt_s < min_q)) begin
                    min_d     = rd_cnt_s;
                    min_way_d = idx_q;
                end else begin
                    min_d = min_q;
                end
                if (idx_q == way_last_lp) begin
                    idx_d      = {lg_ways_lp{1'b0}};
                    victim_v_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    idx_d = idx_q + way_one_lp;
                end
            end
            S_DONE: begin
                if (victim_yumi_i) begin
                    wr_en_s    = 1'b1;
                    wr_set_s   = set_q;
                    wr_way_s   = min_way_q;
                    wr_cnt_s   = cnt_one_lp;
                    victim_v_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_AGE: begin
                wr_en_s  = 1'b1;
                wr_set_s = set_q;
                wr_way_s = idx_q;
                // The saturating hit itself still counts once after halving.
                if (idx_q == age_way_q) begin
                    wr_cnt_s = (rd_cnt_s >> 1) + cnt_one_lp;
                end else begin
                    wr_cnt_s = rd_cnt_s >> 1;
                end
                if (idx_q == way_last_lp) begin
                    idx_d   = {lg_ways_lp{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + way_one_lp;
                end
            end
            default: begin
                state_d    = S_IDLE;
                idx_d      = {lg_ways_lp{1'b0}};
                victim_v_d = 1'b0;
            end
        endcase
    end

    // Control and scan registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            idx_q      <= {lg_ways_lp{1'b0}};
            set_q      <= {lg_sets_lp{1'b0}};
            age_way_q  <= {lg_ways_lp{1'b0}};
            min_q      <= {freq_width_p{1'b0}};
            min_way_q  <= {lg_ways_lp{1'b0}};
            victim_v_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            set_q      <= set_d;
            age_way_q  <= age_way_d;
            min_q      <= min_d;
            min_way_q  <= min_way_d;
            victim_v_q <= victim_v_d;
        end
    end

    // Frequency counter storage.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int s = 0; s < sets_p; s++) begin
                for (int w = 0; w < ways_p; w++) begin
                    cnt_q[s][w] <= {freq_width_p{1'b0}};
                end
            end
        end else if (wr_en_s) begin
            cnt_q[wr_set_s][wr_way_s] <= wr_cnt_s;
        end
    end

endmodule

// File: tb/tb_bsg_lfu_ctrl.sv
// Directed bench for bsg_lfu_ctrl (4 ways, 4 sets, 3-bit counters).
module tb_bsg_lfu_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       hit_v_i = 1'b0;
    logic [1:0] hit_set_i = 2'd0;
    logic [1:0] hit_way_i = 2'd0;
    logic       hit_ready_o;
    logic       victim_v_i = 1'b0;
    logic [1:0] victim_set_i = 2'd0;
    logic       victim_ready_o;
    logic       victim_v_o;
    logic [1:0] victim_way_o;
    logic       victim_yumi_i = 1'b0;

    int tests = 0;
    int fails = 0;

    bsg_lfu_ctrl #(.ways_p(4), .sets_p(4), .freq_width_p(3)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .hit_v_i(hit_v_i), .hit_set_i(hit_set_i), .hit_way_i(hit_way_i),
        .hit_ready_o(hit_ready_o),
        .victim_v_i(victim_v_i), .victim_set_i(victim_set_i),
        .victim_ready_o(victim_ready_o),
        .victim_v_o(victim_v_o), .victim_way_o(victim_way_o),
        .victim_yumi_i(victim_yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic do_hit(input logic [1:0] s, input logic [1:0] w);
        hit_v_i = 1'b1; hit_set_i = s; hit_way_i = w;
        tick();
        hit_v_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [1:0] exp_way);
        int n;
        n = 0;
        while (victim_v_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_way"}, victim_way_o, exp_way);
    endtask

    task automatic run_victim(input string tag, input logic [1:0] s, input logic [1:0] exp_way);
        victim_v_i = 1'b1; victim_set_i = s;
        #1;
        chk({tag, "_ready"}, victim_ready_o, 1);
        tick();
        victim_v_i = 1'b0;
        wait_done(tag, exp_way);
        victim_yumi_i = 1'b1;
        tick();
        victim_yumi_i = 1'b0;
        chk({tag, "_v_drop"}, victim_v_o, 0);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_hit_ready", hit_ready_o, 0);
        chk("rst_victim_ready", victim_ready_o, 0);
        chk("rst_victim_v", victim_v_o, 0);
        chk("rst_victim_way", victim_way_o, 0);
        reset_i = 1'b0;
        #1;
        chk("idle_hit_ready", hit_ready_o, 1);
        tick();

        // All-zero set: ties resolve to way 0; fill sets counter to 1
        run_victim("v_set2", 2'd2, 2'd0);
        chk("fill_cnt_2_0", dut.cnt_q[2][0], 1);
        run_victim("v_set2b", 2'd2, 2'd1);
        chk("fill_cnt_2_1", dut.cnt_q[2][1], 1);

        // Set 1 counts [2,3,1,2] -> way 2
        do_hit(2'd1, 2'd0); do_hit(2'd1, 2'd0);
        do_hit(2'd1, 2'd1); do_hit(2'd1, 2'd1); do_hit(2'd1, 2'd1);
        do_hit(2'd1, 2'd3); do_hit(2'd1, 2'd3);
        do_hit(2'd1, 2'd2);
        chk("hit_cnt_1_1", dut.cnt_q[1][1], 3);
        run_victim("v_set1", 2'd1, 2'd2);
        // Set 3 counts [2,3,2,2] -> tie, way 0
        do_hit(2'd3, 2'd0); do_hit(2'd3, 2'd0);
        do_hit(2'd3, 2'd1); do_hit(2'd3, 2'd1); do_hit(2'd3, 2'd1);
        do_hit(2'd3, 2'd3); do_hit(2'd3, 2'd3);
        do_hit(2'd3, 2'd2); do_hit(2'd3, 2'd2);
        run_victim("v_set3_tie", 2'd3, 2'd0);

        // Saturation ageing: set 0 [2,7,4,0] + hit way 1 -> [1,4,2,0]
        for (int i = 0; i < 7; i++) do_hit(2'd0, 2'd1);
        do_hit(2'd0, 2'd0); do_hit(2'd0, 2'd0);
        for (int i = 0; i < 4; i++) do_hit(2'd0, 2'd2);
        chk("sat_cnt_0_1", dut.cnt_q[0][1], 7);
        chk("pre_age_cnt_0_2", dut.cnt_q[0][2], 4);
        do_hit(2'd0, 2'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("age_hit_ready_%0d", k), hit_ready_o, 0);
            tick();
        end
        chk("age_exit_ready", hit_ready_o, 1);
        chk("age_cnt_0_0", dut.cnt_q[0][0], 1);
        chk("age_cnt_0_1", dut.cnt_q[0][1], 4);
        chk("age_cnt_0_2", dut.cnt_q[0][2], 2);
        chk("age_cnt_0_3", dut.cnt_q[0][3], 0);
        run_victim("v_set0_aged", 2'd0, 2'd3);

        // Simultaneous hit and victim: hit wins, twice; victim taken on third cycle
        hit_v_i = 1'b1; hit_set_i = 2'd2; hit_way_i = 2'd2;
        victim_v_i = 1'b1; victim_set_i = 2'd2;
        #1;
        chk("simul_hit_ready", hit_ready_o, 1);
        chk("simul_victim_ready", victim_ready_o, 0);
        tick();
        chk("simul_hit_cnt", dut.cnt_q[2][2], 1);
        #1;
        chk("simul2_victim_ready", victim_ready_o, 0);
        tick();
        chk("simul2_hit_cnt", dut.cnt_q[2][2], 2);
        hit_v_i = 1'b0;
        #1;
        chk("simul3_victim_ready", victim_ready_o, 1);
        tick();
        victim_v_i = 1'b0;
        wait_done("v_simul", 2'd3);

        // DONE held 10 cycles with a hit pending: nothing moves
        hit_v_i = 1'b1; hit_set_i = 2'd2; hit_way_i = 2'd0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("hold_v_%0d", k), victim_v_o, 1);
            chk($sformatf("hold_way_%0d", k), victim_way_o, 3);
            chk($sformatf("hold_hit_ready_%0d", k), hit_ready_o, 0);
            tick();
        end
        chk("hold_cnt_2_0", dut.cnt_q[2][0], 1);
        hit_v_i = 1'b0;
        victim_yumi_i = 1'b1;
        tick();
        victim_yumi_i = 1'b0;
        chk("hold_yumi_v", victim_v_o, 0);
        chk("hold_fill_cnt_2_3", dut.cnt_q[2][3], 1);
        chk("hold_after_cnt_2_0", dut.cnt_q[2][0], 1);

        // Reset during SCAN cycle 2
        victim_v_i = 1'b1; victim_set_i = 2'd1;
        tick();
        victim_v_i = 1'b0;
        tick();
        reset_i = 1'b1;
        #1;
        chk("midrst_victim_v", victim_v_o, 0);
        chk("midrst_hit_ready", hit_ready_o, 0);
        chk("midrst_victim_ready", victim_ready_o, 0);
        chk("midrst_cnt_0_1", dut.cnt_q[0][1], 0);
        chk("midrst_cnt_2_2", dut.cnt_q[2][2], 0);
        tick();
        reset_i = 1'b0;
        tick();
        for (int s = 0; s < 4; s++) begin
            run_victim($sformatf("post_rst_set%0d", s), 2'(s), 2'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
